// File: rtl/ifu_pcgen.sv
// Instruction-fetch PC generator with a one-entry fetch buffer for the cirno9 core.
// Keeps at most one memory request outstanding; redirects kill the in-flight fetch and the buffer.
module ifu_pcgen #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_setpc,
    input  logic [31:0] i_pc,
    input  logic [31:0] i_pcadd,
    output logic        hs_if4mem_val,
    input  logic        hs_mem4if_rdy,
    output logic [31:0] o_mem_addr,
    input  logic        hs_mem4if_val,
    input  logic [31:0] i_mem_data,
    output logic        hs_if4de_val,
    input  logic        hs_de4if_rdy,
    output logic [31:0] o_ir,
    output logic [31:0] o_ir_pc,
    output logic        o_flush
);

    typedef enum logic [1:0] {
        ST_FETCH     = 2'd0,
        ST_WAIT      = 2'd1,
        ST_WAIT_DROP = 2'd2
    } state_t;

    state_t      state_r;
    state_t      state_s;
    logic [31:0] pc_r;
    logic [31:0] pc_s;
    logic [31:0] req_pc_r;
    logic [31:0] req_pc_s;
    logic        buf_valid_r;
    logic        buf_valid_s;
    logic [31:0] buf_ir_r;
    logic [31:0] buf_ir_s;
    logic [31:0] buf_pc_r;
    logic [31:0] buf_pc_s;
    logic [31:0] tgt_s;
    logic        issue_s;
    logic        deq_s;

    // Redirect target is halfword aligned; the fetch address drops bit 1 separately.
    function automatic logic [31:0] redirect_target(input logic [31:0] base,
                                                    input logic [31:0] ofs);
        logic [31:0] sum;
        sum = base + ofs;
        return {sum[31:1], 1'b0};
    endfunction

    assign tgt_s      = redirect_target(i_pc, i_pcadd);
    assign o_mem_addr = {pc_r[31:2], 2'b00};
    assign o_ir       = buf_ir_r;
    assign o_ir_pc    = buf_pc_r;

    // Handshake outputs: a redirect suppresses both the fetch request and the decoder valid.
    always_comb begin
        hs_if4mem_val = 1'b0;
        hs_if4de_val  = 1'b0;
        o_flush       = 1'b0;
        if (rst) begin
            hs_if4mem_val = 1'b0;
            hs_if4de_val  = 1'b0;
            o_flush       = 1'b0;
        end else begin
            o_flush      = i_setpc;
            hs_if4de_val = buf_valid_r & ~i_setpc;
            if (state_r == ST_FETCH) begin
                hs_if4mem_val = ~i_setpc & (~buf_valid_r | hs_de4if_rdy);
            end else begin
                hs_if4mem_val = 1'b0;
            end
        end
    end

    assign issue_s = hs_if4mem_val & hs_mem4if_rdy;
    assign deq_s   = hs_if4de_val & hs_de4if_rdy;

    // Next-state logic: FSM transitions, PC advance, buffer fill/drain, redirect override.
    always_comb begin
        state_s     = state_r;
        pc_s        = pc_r;
        req_pc_s    = req_pc_r;
        buf_valid_s = buf_valid_r;
        buf_ir_s    = buf_ir_r;
        buf_pc_s    = buf_pc_r;

        if (deq_s) begin
            buf_valid_s = 1'b0;
        end else begin
            buf_valid_s = buf_valid_r;
        end

        case (state_r)
            ST_FETCH: begin
                if (issue_s) begin
                    req_pc_s = pc_r;
                    pc_s     = pc_r + 32'd4;
                    state_s  = ST_WAIT;
                end else begin
                    state_s  = ST_FETCH;
                end
            end
            ST_WAIT: begin
                if (hs_mem4if_val) begin
                    if (!i_setpc) begin
                        buf_ir_s    = i_mem_data;
                        buf_pc_s    = req_pc_r;
                        buf_valid_s = 1'b1;
                    end else begin
                        buf_ir_s    = buf_ir_r;
                    end
                    state_s = ST_FETCH;
                end else if (i_setpc) begin
                    state_s = ST_WAIT_DROP;
                end else begin
                    state_s = ST_WAIT;
                end
            end
            ST_WAIT_DROP: begin
                if (hs_mem4if_val) begin
                    state_s = ST_FETCH;
                end else begin
                    state_s = ST_WAIT_DROP;
                end
            end
            default: begin
                state_s = ST_FETCH;
            end
        endcase

        // Redirect wins over the +4 increment and over any buffer content.
        if (i_setpc) begin
            pc_s        = tgt_s;
            buf_valid_s = 1'b0;
        end else begin
            pc_s        = pc_s;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_FETCH;
            pc_r        <= RESET_PC;
            req_pc_r    <= RESET_PC;
            buf_valid_r <= 1'b0;
            buf_ir_r    <= 32'h0000_0000;
            buf_pc_r    <= RESET_PC;
        end else begin
            state_r     <= state_s;
            pc_r        <= pc_s;
            req_pc_r    <= req_pc_s;
            buf_valid_r <= buf_valid_s;
            buf_ir_r    <= buf_ir_s;
            buf_pc_r    <= buf_pc_s;
        end
    end

endmodule
